// File: rtl/alu_seq_pkg.sv
// Shared definitions for the handshaked sequential ALU.
// Opcodes, op-class encoding, compare result codes and FSM states.
package alu_seq_pkg;
  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_DIV  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_NOR  = 4'h7;
  localparam logic [3:0] OP_NOP  = 4'h8;
  localparam logic [3:0] OP_EQ   = 4'h9;
  localparam logic [3:0] OP_GT   = 4'hA;
  localparam logic [3:0] OP_LT   = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_SHL  = 4'hD;
  localparam logic [3:0] OP_SRA  = 4'hE;
  localparam logic [3:0] OP_ROL  = 4'hF;

  // Op class is the opcode's top two bits.
  typedef enum logic [1:0] {CLS_ARITH, CLS_LOGIC, CLS_CMP, CLS_SHIFT} cls_e;

  localparam logic CMP_FALSE = 1'b0;
  localparam logic CMP_TRUE  = 1'b1;

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_DONE} state_e;

  function automatic cls_e op_class(input logic [3:0] op);
    return cls_e'(op[3:2]);
  endfunction

  // Flag vector order: {SHIFT, CMP, LOGIC, ARITH}
  function automatic logic [3:0] cls_onehot(input cls_e c);
    return 4'b0001 << c;
  endfunction
endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide.
// Ports: i_clk, i_rst (async high), i_start (load operands), i_is_div,
//        i_a, i_b (operands), o_done (final iteration this cycle),
//        o_result (2*WIDTH; valid when o_done: product or {rem, quot}).
// o_result carries the value being written on the last iteration edge so the
// caller can capture it on that same edge.
module alu_iter_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_is_div,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_result
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic             r_busy, r_div;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_m;   // {r_hi,r_lo}: product / {rem,quot}

  logic [WIDTH:0]   w_sum, w_sh, w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_hi_nx, w_lo_nx;

  always_comb begin
    // mul: add multiplicand when multiplier LSB set, shift pair right
    w_sum  = {1'b0, r_hi} + {1'b0, {WIDTH{r_lo[0]}} & r_m};
    // div: shift pair left, trial-subtract divisor from partial remainder
    w_sh   = {r_hi, r_lo[WIDTH-1]};
    w_ge   = (w_sh >= {1'b0, r_m});
    w_diff = w_sh - {1'b0, r_m};
    if (r_div) begin
      w_hi_nx = w_ge ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
      w_lo_nx = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_nx = w_sum[WIDTH:1];
      w_lo_nx = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign o_done   = r_busy && (r_cnt == LAST);
  assign o_result = {w_hi_nx, w_lo_nx};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= 1'b0;
      r_div  <= 1'b0;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_m    <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_div  <= i_is_div;
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= i_is_div ? i_a : i_b;
      r_m    <= i_is_div ? i_b : i_a;
    end else if (r_busy) begin
      r_hi   <= w_hi_nx;
      r_lo   <= w_lo_nx;
      r_cnt  <= r_cnt + CW'(1);
      if (o_done) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq_top.sv
// Handshaked ALU: one op per IN_VALID/IN_READY transfer, result held until
// OUT_VALID/OUT_READY. Single-cycle ops register in one cycle; mul/div
// iterate WIDTH cycles in alu_iter_muldiv.
// Ports: CLK_TOP, RST_TOP (async high); IN_VALID/IN_READY, A_IN, B_IN,
//        ALU_FUN; OUT_VALID/OUT_READY, RESULT (2*WIDTH), CARRY_OUT,
//        ARITH/LOGIC/CMP/SHIFT_Flag (one-hot class), DIV_BY_ZERO.
module alu_seq_top
  import alu_seq_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               CLK_TOP,
  input  logic               RST_TOP,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WIDTH-1:0]   A_IN,
  input  logic [WIDTH-1:0]   B_IN,
  input  logic [3:0]         ALU_FUN,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [2*WIDTH-1:0] RESULT,
  output logic               CARRY_OUT,
  output logic               ARITH_Flag,
  output logic               LOGIC_Flag,
  output logic               CMP_Flag,
  output logic               SHIFT_Flag,
  output logic               DIV_BY_ZERO
);
  state_e             r_state;
  logic               r_valid, r_cy, r_dz;
  logic [2*WIDTH-1:0] r_result;
  logic [3:0]         r_flags;

  logic               w_acc, w_is_md, w_dz, w_cy, w_md_done;
  logic [SHAMT_W-1:0] w_sh;
  logic [2*WIDTH-1:0] w_res, w_rol2, w_md_res;

  assign IN_READY = !RST_TOP &&
                    (r_state == ST_IDLE || (r_state == ST_DONE && OUT_READY));
  assign w_acc    = IN_VALID && IN_READY;
  assign w_is_md  = (ALU_FUN == OP_MUL) || (ALU_FUN == OP_DIV);
  assign w_dz     = (ALU_FUN == OP_DIV) && (B_IN == '0);
  assign w_sh     = B_IN[SHAMT_W-1:0];
  assign w_rol2   = {A_IN, A_IN} << w_sh;   // upper half is the rotate

  always_comb begin
    w_res = '0;
    w_cy  = 1'b0;
    case (ALU_FUN)
      OP_ADD:  {w_cy, w_res[WIDTH-1:0]} = {1'b0, A_IN} + {1'b0, B_IN};
      OP_SUB:  begin
                 w_res[WIDTH-1:0] = A_IN - B_IN;
                 w_cy             = (A_IN < B_IN);
               end
      OP_AND:  w_res[WIDTH-1:0] = A_IN & B_IN;
      OP_OR:   w_res[WIDTH-1:0] = A_IN | B_IN;
      OP_NAND: w_res[WIDTH-1:0] = ~(A_IN & B_IN);
      OP_NOR:  w_res[WIDTH-1:0] = ~(A_IN | B_IN);
      OP_EQ:   w_res[0] = (A_IN == B_IN) ? CMP_TRUE : CMP_FALSE;
      OP_GT:   w_res[0] = (A_IN >  B_IN) ? CMP_TRUE : CMP_FALSE;
      OP_LT:   w_res[0] = (A_IN <  B_IN) ? CMP_TRUE : CMP_FALSE;
      OP_SHR:  w_res[WIDTH-1:0] = A_IN >> w_sh;
      OP_SHL:  w_res[WIDTH-1:0] = A_IN << w_sh;
      OP_SRA:  w_res[WIDTH-1:0] = $signed(A_IN) >>> w_sh;
      OP_ROL:  w_res[WIDTH-1:0] = w_rol2[2*WIDTH-1:WIDTH];
      OP_MUL, OP_DIV, OP_NOP: ;
      default: ;
    endcase
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .i_clk    (CLK_TOP),
    .i_rst    (RST_TOP),
    .i_start  (w_acc && w_is_md && !w_dz),
    .i_is_div (ALU_FUN == OP_DIV),
    .i_a      (A_IN),
    .i_b      (B_IN),
    .o_done   (w_md_done),
    .o_result (w_md_res)
  );

  always_ff @(posedge CLK_TOP or posedge RST_TOP) begin
    if (RST_TOP) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_result <= '0;
      r_cy     <= 1'b0;
      r_flags  <= '0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        ST_CALC: if (w_md_done) begin
          r_state  <= ST_DONE;
          r_valid  <= 1'b1;
          r_result <= w_md_res;
          r_cy     <= 1'b0;
          r_flags  <= cls_onehot(CLS_ARITH);
          r_dz     <= 1'b0;
        end
        default: if (w_acc) begin
          if (w_is_md && !w_dz) begin
            // previous outputs stay on the bus, just not valid
            r_state <= ST_CALC;
            r_valid <= 1'b0;
          end else begin
            r_state  <= ST_DONE;
            r_valid  <= 1'b1;
            r_result <= w_dz ? {A_IN, {WIDTH{1'b1}}} : w_res;
            r_cy     <= w_cy;
            r_flags  <= cls_onehot(op_class(ALU_FUN));
            r_dz     <= w_dz;
          end
        end else if (r_state == ST_DONE && OUT_READY) begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign OUT_VALID   = r_valid;
  assign RESULT      = r_result;
  assign CARRY_OUT   = r_cy;
  assign DIV_BY_ZERO = r_dz;
  assign ARITH_Flag  = r_flags[0];
  assign LOGIC_Flag  = r_flags[1];
  assign CMP_Flag    = r_flags[2];
  assign SHIFT_Flag  = r_flags[3];
endmodule

// File: tb/tb_alu_seq_top.sv
module tb_alu_seq_top;
  localparam int W = 16;
  localparam longint unsigned MASK = 64'hFFFF;

  logic          CLK_TOP = 1'b0, RST_TOP = 1'b1;
  logic          IN_VALID = 1'b0, IN_READY, OUT_VALID, OUT_READY = 1'b0;
  logic [W-1:0]  A_IN = '0, B_IN = '0;
  logic [3:0]    ALU_FUN = '0;
  logic [2*W-1:0] RESULT;
  logic CARRY_OUT, ARITH_Flag, LOGIC_Flag, CMP_Flag, SHIFT_Flag, DIV_BY_ZERO;

  alu_seq_top #(.WIDTH(W)) dut (
    .CLK_TOP(CLK_TOP), .RST_TOP(RST_TOP), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A_IN(A_IN), .B_IN(B_IN), .ALU_FUN(ALU_FUN), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .RESULT(RESULT), .CARRY_OUT(CARRY_OUT),
    .ARITH_Flag(ARITH_Flag), .LOGIC_Flag(LOGIC_Flag), .CMP_Flag(CMP_Flag),
    .SHIFT_Flag(SHIFT_Flag), .DIV_BY_ZERO(DIV_BY_ZERO));

  always #5 CLK_TOP = ~CLK_TOP;

  longint cyc = 0;
  always @(posedge CLK_TOP) cyc <= cyc + 1;

  typedef struct {
    longint unsigned res;
    bit              cy;
    bit [3:0]        fl;     // {SHIFT,CMP,LOGIC,ARITH}
    bit              dz;
    int              lat;
    longint          appear;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: straight from the operation table, plain integer math.
  function automatic exp_t model(input bit [3:0] op, input int unsigned a, input int unsigned b);
    exp_t e;
    int unsigned sh = b % W;
    int sa;
    e = '{res: 0, cy: 0, fl: 4'b0001 << (op / 4), dz: 0, lat: 1, appear: 0};
    case (op)
      4'h0: begin e.res = (a + b) & MASK; e.cy = ((a + b) >> W) != 0; end
      4'h1: begin e.res = (a - b) & MASK; e.cy = (a < b); end
      4'h2: begin e.res = longint'(a) * longint'(b); e.lat = W + 1; end
      4'h3: if (b == 0) begin e.res = (longint'(a) << W) | MASK; e.dz = 1; end
            else begin e.res = (longint'(a % b) << W) | (a / b); e.lat = W + 1; end
      4'h4: e.res = a & b;
      4'h5: e.res = a | b;
      4'h6: e.res = ~(a & b) & MASK;
      4'h7: e.res = ~(a | b) & MASK;
      4'h8: e.res = 0;
      4'h9: e.res = (a == b);
      4'hA: e.res = (a > b);
      4'hB: e.res = (a < b);
      4'hC: e.res = a >> sh;
      4'hD: e.res = (a << sh) & MASK;
      4'hE: begin sa = (a >= 32768) ? int'(a) - 65536 : int'(a); e.res = (sa >>> sh) & 'hFFFF; end
      default: e.res = ((a << sh) | (a >> (W - sh))) & MASK;
    endcase
    return e;
  endfunction

  // Handshake model kept by the driver
  bit     have_out = 0;
  longint busy_until = 0;

  task automatic step(input bit v, input bit [3:0] op, input bit [15:0] a,
                      input bit [15:0] b, input bit ordy, output bit acc);
    bit in_calc, visible, exp_rdy;
    exp_t e;
    @(negedge CLK_TOP);
    #1;
    IN_VALID = v; ALU_FUN = op; A_IN = a; B_IN = b; OUT_READY = ordy;
    #1;
    in_calc = have_out && (cyc < busy_until);
    visible = have_out && (cyc >= busy_until);
    exp_rdy = !in_calc && (!visible || ordy);
    chk("in_ready", IN_READY, exp_rdy);
    chk("out_valid", OUT_VALID, visible);
    acc = v && IN_READY;
    if (visible && ordy) have_out = 0;
    if (acc) begin
      e = model(op, a, b);
      e.appear = cyc + e.lat;
      sb.push_back(e);
      have_out = 1;
      busy_until = e.appear;
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(0, 4'h0, 16'h0, 16'h0, 1, acc);
  endtask

  task automatic send(input bit [3:0] op, input bit [15:0] a, input bit [15:0] b);
    bit acc = 0;
    for (int i = 0; i < 50 && !acc; i++) step(1, op, a, b, 1, acc);
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  // Monitor: pops the scoreboard whenever a new result appears on the bus and
  // checks it every cycle it stays valid.
  exp_t cur;
  bit   have_cur = 0, prev_v = 0, prev_x = 0;
  always begin
    @(negedge CLK_TOP);
    #3;
    if (RST_TOP) begin
      prev_v = 0; prev_x = 0; have_cur = 0;
    end else begin
      if (OUT_VALID && (!prev_v || prev_x)) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
          have_cur = 0;
        end else begin
          cur = sb.pop_front();
          have_cur = 1;
          chk("latency_cycle", cyc, cur.appear);
        end
      end
      if (OUT_VALID && have_cur) begin
        chk("result", RESULT, cur.res);
        chk("carry_out", CARRY_OUT, cur.cy);
        chk("class_flags", {SHIFT_Flag, CMP_Flag, LOGIC_Flag, ARITH_Flag}, cur.fl);
        chk("div_by_zero", DIV_BY_ZERO, cur.dz);
      end
      prev_v = OUT_VALID;
      prev_x = OUT_VALID && OUT_READY;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit [15:0] ra, rb;
    // reset state
    repeat (3) @(negedge CLK_TOP);
    #1;
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_flags", {SHIFT_Flag, CMP_Flag, LOGIC_Flag, ARITH_Flag, CARRY_OUT, DIV_BY_ZERO}, 0);
    RST_TOP = 0;

    // directed: arith, mul/div, shifts, compares
    send(4'h0, 16'd24, 16'd4);       idle(2);
    send(4'h1, 16'd4, 16'd24);       idle(2);
    send(4'h2, 16'hFFFF, 16'hFFFF);  idle(20);
    send(4'h3, 16'd25, 16'd4);       idle(20);
    send(4'h3, 16'd24, 16'd0);       idle(2);
    for (int op = 12; op < 16; op++) send(4'(op), 16'h8001, 16'd4);
    send(4'hA, 16'd24, 16'd4);
    send(4'hB, 16'd24, 16'd4);
    send(4'h9, 16'd24, 16'd4);
    send(4'h8, 16'd24, 16'd24);
    for (int op = 4; op < 8; op++) send(4'(op), 16'hF0A5, 16'h3C3C);
    idle(2);

    // backpressure: result held, input refused, then seamless replace
    step(1, 4'h0, 16'd24, 16'd4, 1, acc);
    for (int i = 0; i < 5; i++) step(1, 4'h5, 16'h1200, 16'h0034, 0, acc);
    step(1, 4'h5, 16'h1200, 16'h0034, 1, acc);
    chk("bp_accept_on_ready", acc, 1);
    idle(3);

    // reset in the middle of a multiply
    send(4'h2, 16'h1234, 16'h5678);
    idle(4);
    @(negedge CLK_TOP);
    #1;
    RST_TOP = 1;
    #1;
    chk("mid_rst_in_ready", IN_READY, 0);
    chk("mid_rst_out_valid", OUT_VALID, 0);
    chk("mid_rst_result", RESULT, 0);
    chk("mid_rst_flags", {SHIFT_Flag, CMP_Flag, LOGIC_Flag, ARITH_Flag, CARRY_OUT, DIV_BY_ZERO}, 0);
    sb.delete();
    have_out = 0;
    repeat (2) @(negedge CLK_TOP);
    #1;
    RST_TOP = 0;
    idle(W + 4);   // no stale completion may surface
    send(4'h0, 16'hFFFF, 16'h0001);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 2500; i++) begin
      case ($urandom_range(0, 3))
        0: ra = 16'h0000;
        1: ra = 16'hFFFF;
        2: ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
      step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ra, rb,
           $urandom_range(0, 3) != 0, acc);
    end
    idle(W + 6);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
